// File: rtl/npu_mac_feeder_if.sv
// Bundle of command, operand-memory, MAC-lane and result signals for npu_mac_feeder.
// master = the feeder itself, slave = the surrounding environment.
interface npu_mac_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 8,
  parameter int NOUT_WIDTH = 6
);
  // command from the layer controller
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [LEN_WIDTH-1:0]         cmd_len;
  logic [NOUT_WIDTH-1:0]        cmd_num_out;
  logic [ADDR_WIDTH-1:0]        cmd_w_base;
  logic [ADDR_WIDTH-1:0]        cmd_a_base;
  // operand memories (synchronous read, data one cycle after rd_en)
  logic                         w_rd_en;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic signed [DATA_WIDTH-1:0] w_rdata;
  logic                         a_rd_en;
  logic [ADDR_WIDTH-1:0]        a_addr;
  logic signed [DATA_WIDTH-1:0] a_rdata;
  // MAC lane
  logic                         mac_en;
  logic                         start_p;
  logic                         last_p;
  logic signed [DATA_WIDTH-1:0] weight_out;
  logic signed [DATA_WIDTH-1:0] act_out;
  logic signed [DATA_WIDTH-1:0] mac_out;
  logic                         mac_valid;
  logic                         mac_overflow;
  // results
  logic                         res_valid;
  logic signed [DATA_WIDTH-1:0] res_data;
  logic [NOUT_WIDTH-1:0]        res_idx;
  logic                         job_overflow;
  logic                         done;

  modport master (
    input  cmd_valid, cmd_len, cmd_num_out, cmd_w_base, cmd_a_base,
    input  w_rdata, a_rdata, mac_out, mac_valid, mac_overflow,
    output cmd_ready, w_rd_en, w_addr, a_rd_en, a_addr,
    output mac_en, start_p, last_p, weight_out, act_out,
    output res_valid, res_data, res_idx, job_overflow, done
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_num_out, cmd_w_base, cmd_a_base,
    output w_rdata, a_rdata, mac_out, mac_valid, mac_overflow,
    input  cmd_ready, w_rd_en, w_addr, a_rd_en, a_addr,
    input  mac_en, start_p, last_p, weight_out, act_out,
    input  res_valid, res_data, res_idx, job_overflow, done
  );
endinterface

// File: rtl/npu_mac_feeder.sv
// npu_mac_feeder: walks weight rows and the activation vector for one command,
// streams operand pairs with start/last framing into an npu_mac lane and
// tags each returned dot product with its output index.
module npu_mac_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 8,
  parameter int NOUT_WIDTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  npu_mac_feeder_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state, state_nxt;
  logic [LEN_WIDTH-1:0]         len_q, i_cnt;
  logic [NOUT_WIDTH-1:0]        nout_q, o_cnt, res_cnt;
  logic [ADDR_WIDTH-1:0]        a_base_q, w_ptr, a_ptr;
  logic                         accept, cmd_zero, row_end, last_issue;
  logic                         mac_en_p1, start_p1, last_p1;
  logic                         res_valid_p2;
  logic signed [DATA_WIDTH-1:0] res_data_p2;
  logic [NOUT_WIDTH-1:0]        res_idx_p2;
  logic                         job_ovf_q;

  assign accept     = (state == IDLE) && bus.cmd_valid;
  assign cmd_zero   = (bus.cmd_len == '0) || (bus.cmd_num_out == '0);
  assign row_end    = (i_cnt == len_q - LEN_WIDTH'(1));
  assign last_issue = row_end && (o_cnt == nout_q - NOUT_WIDTH'(1));

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the state-derived outputs (ready, done, reads).
  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.done      = 1'b0;
    bus.w_rd_en   = 1'b0;
    bus.a_rd_en   = 1'b0;
    bus.w_addr    = '0;
    bus.a_addr    = '0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (accept) state_nxt = cmd_zero ? DONE : RUN;
      end
      RUN: begin
        bus.w_rd_en = 1'b1;
        bus.a_rd_en = 1'b1;
        bus.w_addr  = w_ptr;
        bus.a_addr  = a_ptr;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: if (res_cnt == nout_q) state_nxt = DONE;
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue side: latch the command, then step term/row counters and pointers.
  // The activation pointer rewinds at each row end; weight rows are contiguous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      nout_q   <= '0;
      a_base_q <= '0;
      w_ptr    <= '0;
      a_ptr    <= '0;
      i_cnt    <= '0;
      o_cnt    <= '0;
    end else if (accept) begin
      len_q    <= bus.cmd_len;
      nout_q   <= bus.cmd_num_out;
      a_base_q <= bus.cmd_a_base;
      w_ptr    <= bus.cmd_w_base;
      a_ptr    <= bus.cmd_a_base;
      i_cnt    <= '0;
      o_cnt    <= '0;
    end else if (state == RUN) begin
      w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (row_end) begin
        i_cnt <= '0;
        o_cnt <= o_cnt + NOUT_WIDTH'(1);
        a_ptr <= a_base_q;
      end else begin
        i_cnt <= i_cnt + LEN_WIDTH'(1);
        a_ptr <= a_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // ---- stage p1: framing delayed one cycle so it lines up with read data ----
  // Framing flops follow the issue cycle by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_en_p1 <= 1'b0;
      start_p1  <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      mac_en_p1 <= (state == RUN);
      start_p1  <= (state == RUN) && (i_cnt == '0);
      last_p1   <= (state == RUN) && row_end;
    end
  end

  assign bus.mac_en     = mac_en_p1;
  assign bus.start_p    = start_p1;
  assign bus.last_p     = last_p1;
  assign bus.weight_out = bus.w_rdata;
  assign bus.act_out    = bus.a_rdata;

  // ---- stage p2: result capture from the MAC lane ----
  // Capture each in-job MAC result with its index; track sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_p2 <= 1'b0;
      res_data_p2  <= '0;
      res_idx_p2   <= '0;
      res_cnt      <= '0;
      job_ovf_q    <= 1'b0;
    end else begin
      res_valid_p2 <= 1'b0;
      if (accept) begin
        res_cnt   <= '0;
        job_ovf_q <= 1'b0;
      end else if (state != IDLE) begin
        if (bus.mac_overflow) job_ovf_q <= 1'b1;
        if (bus.mac_valid) begin
          res_valid_p2 <= 1'b1;
          res_data_p2  <= bus.mac_out;
          res_idx_p2   <= res_cnt;
          res_cnt      <= res_cnt + NOUT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.res_valid    = res_valid_p2;
  assign bus.res_data     = res_data_p2;
  assign bus.res_idx      = res_idx_p2;
  assign bus.job_overflow = job_ovf_q;
endmodule
